rr_burst_mux: RTL
=================

// Module: rr_burst_mux
// PURPOSE
//  - Downstream consumer of round_robin_arbiter grants. Requester channels present valid/data/last beats.
//  - The block drives the arbiter's req from channel valids and captures a one-hot gnt.
//  - It locks onto the granted channel for a whole burst (until last) and forwards beats through a 1-entry output register.
//  - Sits between N producer channels and a single shared sink.
// PARAMETERS
//  N          5    number of requester channels (matches arbiter N)
//  W          32   payload width per beat
//  MAX_BEATS  16   longest legal burst; lock force-released after this many beats
//  IDXW       $clog2(N)  width of source index (derived, do not override)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   N      per-channel beat valid
//  in_data    in   N*W    per-channel payload, channel i at [i*W +: W]
//  in_last    in   N      per-channel end-of-burst marker
//  in_ready   out  N      per-channel accept; at most one bit high
//  arb_req    out  N      request vector to arbiter
//  gnt        in   N      one-hot grant from arbiter
//  out_valid  out  1      output beat valid
//  out_data   out  W      output payload
//  out_last   out  1      output end-of-burst
//  out_src    out  IDXW   channel index of current output beat
//  out_ready  in   1      sink accept
//  gnt_err    out  1      sticky: illegal grant or burst overrun seen
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=0, arb_req=0, out_valid=0, out_data=0, out_last=0, out_src=0, gnt_err=0, beat_cnt=0.
//  - FSM states: IDLE and BURST.
//    - IDLE: arb_req = in_valid; in_ready = 0.
//      - On a clock with gnt one-hot and in_valid[idx(gnt)]=1: latch sel=idx(gnt), beat_cnt=0, go BURST.
//      - gnt==0: stay IDLE, no error.
//      - gnt multi-hot: stay IDLE, set gnt_err.
//      - Grant to a channel whose valid is low: ignored, stay IDLE.
//    - BURST: arb_req = 0 (arbiter sees idle; pointer holds). in_ready[sel] = !out_valid | out_ready; all other bits 0.
//      - Beat accepted when in_valid[sel] & in_ready[sel]; beat_cnt increments.
//      - Accepted beat with in_last=1: return to IDLE on the next edge.
//      - Accepted beat with beat_cnt==MAX_BEATS-1 and in_last=0: return to IDLE, set gnt_err; beat forwarded with out_last=0.
//  - Output register:
//    - Loads {data,last,sel} on every accepted beat and sets out_valid.
//    - Clears out_valid on out_valid & out_ready with no new load.
//    - Simultaneous drain and load: register reloads, out_valid stays 1.
//    - Latency: input beat to out_valid is 1 cycle. Full throughput of 1 beat/cycle when out_ready is held high.
//  - Back-pressure: out_valid=1 and out_ready=0 drops in_ready[sel] combinationally. out_* stay stable until accepted.
//  - Minimum gap: one IDLE cycle between bursts, used for the grant capture. Back-to-back bursts therefore take 1 bubble.
//  - beat_cnt width is $clog2(MAX_BEATS+1); it saturates and never wraps.
//  - gnt_err clears only on rst.
//  - Reset mid-burst: immediate return to reset values. The partial burst is dropped; no out_last is emitted.
// STRUCTURE
//  - arb_pkg holds:
//    - state enum {IDLE, BURST}
//    - function onehot_is_legal (exactly one bit set)
//    - default N and W constants, shared with round_robin_arbiter
//  - Sub-module onehot_to_bin #(N): one-hot to index encoder, plus a multi-hot detect output.
//  - The top level holds the FSM, beat counter, payload mux (in_data[sel*W +: W]) and the output register.
// TESTING
//  1. rst=1 then 0. Check: all outputs 0.
//     Then in_valid=00001, gnt=00001, 3-beat burst (A,B,C last), out_ready=1.
//     Expect: out_data A,B,C on consecutive cycles; out_src=0; out_last only on C; then IDLE with arb_req=00001 if valid still high.
//  2. in_valid=00110, gnt=00010, then 2-beat burst on ch1.
//     Expect: in_ready=00010 only; ch2 in_ready stays 0 throughout; arb_req=0 during burst.
//  3. out_ready=0 for 3 cycles mid-burst.
//     Expect: out_data held; in_ready[sel]=0; no beats lost or duplicated after out_ready=1.
//  4. gnt=00011 in IDLE.
//     Expect: no lock, gnt_err=1 and stays 1. Then gnt=01000 with in_valid[3]=1: locks ch3.
//  5. 17 beats with no last on ch4, MAX_BEATS=16.
//     Expect: 16 beats forwarded, last with out_last=0; FSM to IDLE; gnt_err=1.
//  6. rst asserted after beat 2 of a 4-beat burst.
//     Expect: out_valid=0 and in_ready=0 asynchronously. A new grant after release locks normally.

Source files
------------

// File: rtl/arb_pkg.sv
// Types and constants shared by the grant-consuming mux and round_robin_arbiter.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int ARB_N = 5;
    localparam int ARB_W = 32;

    // True when exactly one bit of the (zero-extended) vector is set.
    function automatic logic onehot_is_legal(input logic [31:0] vec);
        return $countones(vec) == 1;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary index encoder with a multi-hot flag.
module onehot_to_bin #(
    parameter int N    = 5,
    parameter int IDXW = $clog2(N)
) (
    input  logic [N-1:0]    onehot,
    output logic [IDXW-1:0] idx,
    output logic            multi
);

    // OR-reduce indices so a legal one-hot input yields its position directly.
    always_comb begin
        logic seen;
        idx   = '0;
        multi = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                idx = idx | IDXW'(i);
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_burst_mux.sv
// Locks onto an arbiter-granted channel for a whole burst and forwards its
// beats through a single output register to a shared sink.
module rr_burst_mux
    import arb_pkg::*;
#(
    parameter int N         = ARB_N,
    parameter int W         = ARB_W,
    parameter int MAX_BEATS = 16,
    parameter int IDXW      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    in_valid,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_last,
    output logic [N-1:0]    in_ready,
    output logic [N-1:0]    arb_req,
    input  logic [N-1:0]    gnt,
    output logic            out_valid,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic [IDXW-1:0] out_src,
    input  logic            out_ready,
    output logic            gnt_err
);

    localparam int CNTW = $clog2(MAX_BEATS + 1);

    state_t            state;
    state_t            next_state;
    logic [IDXW-1:0]   sel;
    logic [CNTW-1:0]   beat_cnt;
    logic [IDXW-1:0]   gnt_idx;
    logic              gnt_multi;
    logic              gnt_legal;
    logic              lock;
    logic              beat_accept;
    logic              err_set;
    logic [W-1:0]      sel_data;
    logic              sel_last;

    onehot_to_bin #(
        .N    (N),
        .IDXW (IDXW)
    ) u_gnt_enc (
        .onehot (gnt),
        .idx    (gnt_idx),
        .multi  (gnt_multi)
    );

    assign gnt_legal = onehot_is_legal(32'(gnt));
    assign sel_data  = in_data[int'(sel)*W +: W];
    assign sel_last  = in_last[sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Arbiter only sees requests while idle, so its pointer holds during a burst.
    always_comb begin
        next_state  = state;
        arb_req     = '0;
        in_ready    = '0;
        lock        = 1'b0;
        beat_accept = 1'b0;
        err_set     = 1'b0;
        case (state)
            IDLE: begin
                arb_req = in_valid;
                if (gnt_multi) begin
                    err_set = 1'b1;
                end else if (gnt_legal && in_valid[gnt_idx]) begin
                    lock       = 1'b1;
                    next_state = BURST;
                end
            end
            BURST: begin
                in_ready[sel] = !out_valid || out_ready;
                beat_accept   = in_valid[sel] && in_ready[sel];
                if (beat_accept) begin
                    if (sel_last) begin
                        next_state = IDLE;
                    end else if (beat_cnt == CNTW'(MAX_BEATS - 1)) begin
                        next_state = IDLE;
                        err_set    = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel      <= '0;
            beat_cnt <= '0;
            gnt_err  <= 1'b0;
        end else begin
            if (lock) begin
                sel      <= gnt_idx;
                beat_cnt <= '0;
            end else if (beat_accept && beat_cnt != CNTW'(MAX_BEATS)) begin
                beat_cnt <= beat_cnt + CNTW'(1);
            end
            if (err_set) begin
                gnt_err <= 1'b1;
            end
        end
    end

    // A load wins over a drain, so drain+load in one cycle keeps out_valid high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (beat_accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_src   <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
